gray_seq_ctrl: RTL and testbench

Sequencer that drives the team's binary-to-Gray converter through a programmable run of consecutive codes and hands each Gray code to a downstream consumer over a valid/ready handshake. A start command loads a binary start value, direction and length. The block then steps a binary counter modulo 2^WIDTH, converting each value to Gray and emitting one code per accepted beat. It sits between a control/CSR source and any Gray-coded consumer (position encoder model, async pointer test source).

---
 rtl/gray_seq_pkg.sv | 18 +
 rtl/gray_seq_ctrl_if.sv | 30 +++
 rtl/b2g_conv.sv | 13 +
 rtl/gray_seq_ctrl.sv | 111 +++++++++++
 tb/tb_gray_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_seq_pkg.sv
// Shared types, default sizes and the binary-to-Gray helper for the Gray sequencer.
package gray_seq_pkg;

    localparam int unsigned WIDTH_DEF = 3;
    localparam int unsigned LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Reflected binary code of a value of up to 32 bits.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// Command, stream and status signals between a controller and the Gray sequencer.
interface gray_seq_ctrl_if
    import gray_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
);
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] start_bin;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             wrap;
    logic             busy;
    logic             done;

    modport master (
        output start, dir, start_bin, len, abort, out_ready,
        input  out_valid, gray_out, bin_out, wrap, busy, done
    );

    modport slave (
        input  start, dir, start_bin, len, abort, out_ready,
        output out_valid, gray_out, bin_out, wrap, busy, done
    );
endinterface

// File: rtl/b2g_conv.sv
// Purely combinational binary-to-Gray converter.
module b2g_conv
    import gray_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_c
);

    assign gray_c = WIDTH'(bin2gray(32'(bin_i)));

endmodule

// File: rtl/gray_seq_ctrl.sv
// Steps a modulo-2^WIDTH counter for a programmed run length and streams its Gray codes.
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    gray_seq_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EMIT = EMIT;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hs;

    assign hs = out_valid_q & bus.out_ready;

    // Gray code is computed from the next counter value so it lands in a flop alongside bin_q.
    b2g_conv #(.WIDTH(WIDTH)) u_b2g (
        .bin_i  (bin_d),
        .gray_c (gray_d)
    );

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        state_d = S_EMIT;
                        bin_d   = bus.start_bin;
                        rem_d   = bus.len;
                        dir_d   = bus.dir;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_EMIT: begin
                if (hs) begin
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                        rem_d   = '0;
                    end else begin
                        bin_d = dir_q ? bin_q - WIDTH'(1) : bin_q + WIDTH'(1);
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
                // A same-cycle handshake still counts; abort only kills the remainder.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        out_valid_d = (state_d == S_EMIT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bin_q       <= '0;
            gray_q      <= '0;
            rem_q       <= '0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            gray_q      <= gray_d;
            rem_q       <= rem_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.gray_out  = gray_q;
    assign bus.bin_out   = bin_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wrap      = out_valid_q & (dir_q ? (bin_q == '0) : (bin_q == '1));

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl: directed scenarios plus randomized runs against a run-level model.
module tb_gray_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gray_seq_ctrl_if #(.WIDTH(3), .LEN_W(8)) bus ();

    gray_seq_ctrl #(.WIDTH(3), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int obs_bin[$];
    int obs_gray[$];
    int obs_wrap[$];
    int obs_cyc[$];
    int vlog[$];
    int done_cnt, done_cyc, idle_cyc, unstable;
    bit timed_out, abort_in_emit;

    // Reference Gray table for 3-bit values, written out by hand.
    int gray_tab[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    // k-th value of a run: start plus/minus k, modulo 8.
    function automatic int exp_bin(input int sb, input bit d, input int k);
        return d ? (((sb - k) % 8) + 8) % 8 : (sb + k) % 8;
    endfunction

    function automatic int exp_wrap(input bit d, input int b);
        return d ? int'(b == 0) : int'(b == 7);
    endfunction

    // Issue a start pulse at a negedge; returns at the next negedge.
    task automatic issue_start(input int sb, input bit d, input int l);
        bus.start_bin = 3'(sb);
        bus.dir       = d;
        bus.len       = 8'(l);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Run the consumer side until the block goes idle, logging every observation.
    task automatic drain(input int max_cyc, input bit rnd, input logic [63:0] mask,
                         input int abort_at, input int start_at);
        logic rdy;
        bit   prev_stall;
        int   pg, pb, pw;
        obs_bin.delete(); obs_gray.delete(); obs_wrap.delete(); obs_cyc.delete(); vlog.delete();
        done_cnt = 0; done_cyc = -1; idle_cyc = -1; unstable = 0;
        timed_out = 1'b1; abort_in_emit = 1'b0; prev_stall = 1'b0;
        pg = 0; pb = 0; pw = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if (c > 0) @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.gray_out !== 3'(pg) ||
                               bus.bin_out !== 3'(pb) || bus.wrap !== 1'(pw)))
                unstable++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            if (bus.out_valid === 1'b1) vlog.push_back(int'(bus.gray_out));
            if (bus.busy === 1'b0) begin
                idle_cyc  = c;
                timed_out = 1'b0;
                break;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : ((c < 64) ? mask[c] : 1'b1);
            bus.out_ready = rdy;
            if (c == abort_at) begin
                bus.abort = 1'b1;
                if (bus.out_valid === 1'b1) abort_in_emit = 1'b1;
            end
            if (c == start_at) bus.start = 1'b1;
            if (bus.out_valid === 1'b1 && rdy) begin
                obs_bin.push_back(int'(bus.bin_out));
                obs_gray.push_back(int'(bus.gray_out));
                obs_wrap.push_back(int'(bus.wrap));
                obs_cyc.push_back(c);
            end
            prev_stall = (bus.out_valid === 1'b1) && !rdy && (c != abort_at);
            pg = int'(bus.gray_out);
            pb = int'(bus.bin_out);
            pw = int'(bus.wrap);
        end
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dir = 1'b0; bus.start_bin = '0; bus.len = '0;
        bus.abort = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.gray_out !== 3'd0) begin errors++; $display("FAIL reset_gray: got %0d expected 0", bus.gray_out); end
        checks++; if (bus.bin_out !== 3'd0) begin errors++; $display("FAIL reset_bin: got %0d expected 0", bus.bin_out); end
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", bus.wrap); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_count_up();
        int exp_g[10] = '{7, 5, 4, 0, 1, 3, 2, 6, 7, 5};
        issue_start(5, 1'b0, 10);
        drain(100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL up_timeout: run did not return to idle"); end
        checks++; if (obs_gray.size() != 10) begin errors++; $display("FAIL up_beats: got %0d expected 10", obs_gray.size()); end
        for (int i = 0; i < 10 && i < obs_gray.size(); i++) begin
            checks++; if (obs_gray[i] != exp_g[i]) begin errors++; $display("FAIL up_gray[%0d]: got %0d expected %0d", i, obs_gray[i], exp_g[i]); end
            checks++; if (obs_cyc[i] != i) begin errors++; $display("FAIL up_cycle[%0d]: got %0d expected %0d", i, obs_cyc[i], i); end
            checks++; if (obs_wrap[i] != exp_wrap(1'b0, exp_bin(5, 1'b0, i))) begin errors++; $display("FAIL up_wrap[%0d]: got %0d expected %0d", i, obs_wrap[i], exp_wrap(1'b0, exp_bin(5, 1'b0, i))); end
        end
        checks++; if (done_cnt != 1 || done_cyc != 10) begin errors++; $display("FAIL up_done: count %0d at cycle %0d expected 1 at 10", done_cnt, done_cyc); end
        checks++; if (idle_cyc != 11) begin errors++; $display("FAIL up_idle: got cycle %0d expected 11", idle_cyc); end
    endtask

    task automatic test_count_down();
        int exp_g[3] = '{1, 0, 4};
        int exp_w[3] = '{0, 1, 0};
        issue_start(1, 1'b1, 3);
        // Abort during the DONE cycle must be ignored.
        drain(100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3, -1);
        checks++; if (obs_gray.size() != 3) begin errors++; $display("FAIL dn_beats: got %0d expected 3", obs_gray.size()); end
        for (int i = 0; i < 3 && i < obs_gray.size(); i++) begin
            checks++; if (obs_gray[i] != exp_g[i]) begin errors++; $display("FAIL dn_gray[%0d]: got %0d expected %0d", i, obs_gray[i], exp_g[i]); end
            checks++; if (obs_wrap[i] != exp_w[i]) begin errors++; $display("FAIL dn_wrap[%0d]: got %0d expected %0d", i, obs_wrap[i], exp_w[i]); end
        end
        checks++; if (done_cnt != 1 || done_cyc != 3) begin errors++; $display("FAIL dn_done: count %0d at cycle %0d expected 1 at 3", done_cnt, done_cyc); end
        checks++; if (idle_cyc != 4) begin errors++; $display("FAIL dn_busy_fall: got cycle %0d expected 4", idle_cyc); end
    endtask

    task automatic test_backpressure();
        int exp_v[7] = '{0, 1, 1, 1, 1, 3, 2};
        issue_start(0, 1'b0, 4);
        drain(100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1, -1, -1);
        checks++; if (vlog.size() != 7) begin errors++; $display("FAIL bp_valid_cycles: got %0d expected 7", vlog.size()); end
        for (int i = 0; i < 7 && i < vlog.size(); i++) begin
            checks++; if (vlog[i] != exp_v[i]) begin errors++; $display("FAIL bp_gray[%0d]: got %0d expected %0d", i, vlog[i], exp_v[i]); end
        end
        checks++; if (obs_gray.size() != 4) begin errors++; $display("FAIL bp_beats: got %0d expected 4", obs_gray.size()); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
        checks++; if (done_cnt != 1 || done_cyc != 7) begin errors++; $display("FAIL bp_done: count %0d at cycle %0d expected 1 at 7", done_cnt, done_cyc); end
    endtask

    task automatic test_len_zero_and_busy_start();
        int exp_g[3] = '{3, 2, 6};
        issue_start(3, 1'b0, 0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL len0_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b expected 1", bus.done); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL len0_busy: got %b expected 1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL len0_idle: done %b busy %b valid %b expected 0 0 0", bus.done, bus.busy, bus.out_valid); end
        // Start pulse during EMIT with different fields must be ignored.
        issue_start(2, 1'b0, 3);
        bus.start_bin = 3'd6; bus.len = 8'd5;
        drain(100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1);
        checks++; if (obs_gray.size() != 3) begin errors++; $display("FAIL busy_start_beats: got %0d expected 3", obs_gray.size()); end
        for (int i = 0; i < 3 && i < obs_gray.size(); i++) begin
            checks++; if (obs_gray[i] != exp_g[i]) begin errors++; $display("FAIL busy_start_gray[%0d]: got %0d expected %0d", i, obs_gray[i], exp_g[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done: got %0d expected 1", done_cnt); end
        // Start pulse during DONE must not be queued.
        issue_start(1, 1'b1, 2);
        bus.start_bin = 3'd4; bus.len = 8'd3;
        drain(100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, -1, 2);
        checks++; if (obs_gray.size() != 2 || done_cnt != 1) begin errors++; $display("FAIL done_start_run: beats %0d done %0d expected 2 1", obs_gray.size(), done_cnt); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL done_start_queued: busy %b valid %b expected 0 0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_abort();
        int exp_g[3] = '{6, 2, 3};
        issue_start(2, 1'b0, 6);
        drain(100, 1'b0, 64'h3, 2, -1);
        checks++; if (obs_bin.size() != 2) begin errors++; $display("FAIL abort_beats: got %0d expected 2", obs_bin.size()); end
        checks++; if (idle_cyc != 3) begin errors++; $display("FAIL abort_idle: got cycle %0d expected 3", idle_cyc); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", bus.out_valid); end
        issue_start(4, 1'b1, 3);
        drain(100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1);
        checks++; if (obs_gray.size() != 3 || done_cnt != 1) begin errors++; $display("FAIL post_abort_run: beats %0d done %0d expected 3 1", obs_gray.size(), done_cnt); end
        for (int i = 0; i < 3 && i < obs_gray.size(); i++) begin
            checks++; if (obs_gray[i] != exp_g[i]) begin errors++; $display("FAIL post_abort_gray[%0d]: got %0d expected %0d", i, obs_gray[i], exp_g[i]); end
        end
        // Abort together with a handshake: that beat still counts.
        issue_start(0, 1'b0, 5);
        drain(100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, -1);
        checks++; if (obs_bin.size() != 2 || done_cnt != 0 || idle_cyc != 2) begin
            errors++; $display("FAIL abort_hs: beats %0d done %0d idle %0d expected 2 0 2", obs_bin.size(), done_cnt, idle_cyc); end
    endtask

    task automatic test_async_rst();
        int exp_g[2] = '{5, 4};
        issue_start(0, 1'b0, 8);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.gray_out !== 3'd0 || bus.bin_out !== 3'd0 ||
                      bus.wrap !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL async_rst: valid %b gray %0d bin %0d wrap %b busy %b done %b expected all 0",
                               bus.out_valid, bus.gray_out, bus.bin_out, bus.wrap, bus.busy, bus.done); end
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue_start(6, 1'b0, 2);
        drain(100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1);
        checks++; if (obs_gray.size() != 2 || done_cnt != 1) begin errors++; $display("FAIL rst_restart_run: beats %0d done %0d expected 2 1", obs_gray.size(), done_cnt); end
        for (int i = 0; i < 2 && i < obs_gray.size(); i++) begin
            checks++; if (obs_gray[i] != exp_g[i]) begin errors++; $display("FAIL rst_restart_gray[%0d]: got %0d expected %0d", i, obs_gray[i], exp_g[i]); end
        end
    endtask

    task automatic test_random();
        int sb, l, ab, eb;
        bit d;
        for (int r = 0; r < 25; r++) begin
            sb = int'($urandom_range(0, 7));
            d  = 1'($urandom_range(0, 1));
            l  = (r == 0) ? 255 : int'($urandom_range(0, 20));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            issue_start(sb, d, l);
            drain(3000, 1'b1, 64'h0, ab, -1);
            checks++; if (timed_out) begin errors++; $display("FAIL rnd%0d_timeout: no return to idle", r); end
            for (int i = 0; i < obs_bin.size(); i++) begin
                eb = exp_bin(sb, d, i);
                checks++; if (obs_bin[i] != eb || obs_gray[i] != gray_tab[eb] || obs_wrap[i] != exp_wrap(d, eb)) begin
                    errors++; $display("FAIL rnd%0d_beat[%0d]: bin %0d gray %0d wrap %0d expected %0d %0d %0d",
                                       r, i, obs_bin[i], obs_gray[i], obs_wrap[i], eb, gray_tab[eb], exp_wrap(d, eb)); end
            end
            checks++; if (abort_in_emit ? (obs_bin.size() > l) : (obs_bin.size() != l)) begin
                errors++; $display("FAIL rnd%0d_beats: got %0d for len %0d aborted %0d", r, obs_bin.size(), l, abort_in_emit); end
            checks++; if (done_cnt != (abort_in_emit ? 0 : 1)) begin
                errors++; $display("FAIL rnd%0d_done: got %0d expected %0d", r, done_cnt, abort_in_emit ? 0 : 1); end
            checks++; if (unstable != 0) begin errors++; $display("FAIL rnd%0d_stable: got %0d changes expected 0", r, unstable); end
            if (done_cnt == 1) begin
                checks++; if (idle_cyc != done_cyc + 1) begin errors++; $display("FAIL rnd%0d_busy_fall: got %0d expected %0d", r, idle_cyc, done_cyc + 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_backpressure();
        test_len_zero_and_busy_start();
        test_abort();
        test_async_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
